// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'hD503201F;
  localparam int          PC_INCR   = 4;

endpackage

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - program counter register with load enable and async active-low reset
module pc_reg #(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic [PC_W-1:0] pc_d_i,
  output logic [PC_W-1:0] pc_q_o
);

  logic [PC_W-1:0] pc_q;

  // Hold the PC unless the fetch unit asks for a new value
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= RESET_PC;
    end else if (load_i) begin
      pc_q <= pc_d_i;
    end
  end

  assign pc_q_o = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - IF stage: PC, single-outstanding imem fetch, IF/ID outputs; optional FETCH_ALIGN_CHECK_EN
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 64,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_target,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic [PC_W-1:0]    currPC,
  output logic [PC_W-1:0]    pc_plus4,
  output logic               IF_ID_flush,
  output logic               fetch_valid
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic               align_fault
`endif
);

  localparam logic [INSTR_W-1:0] NOP_W = INSTR_W'(NOP_INSTR);

  fetch_state_t     state_q;
  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  pc_d;
  logic             pc_load;
  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  br_target_aligned;
  logic             br_fault;
  logic             req_q;
  logic             flush_q;
  logic             valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [PC_W-1:0]  curr_pc_q;
  logic [PC_W-1:0]  pc_plus4_q;

  assign pc_inc            = pc_q + PC_W'(PC_INCR);
  assign br_target_aligned = {br_target[PC_W-1:2], 2'b00};

`ifdef FETCH_ALIGN_CHECK_EN
  logic align_fault_q;
  assign br_fault    = (br_target[1:0] != 2'b00);
  assign align_fault = align_fault_q;
`else
  assign br_fault = 1'b0;
`endif

  pc_reg #(
    .PC_W    (PC_W),
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk_i (clk),
    .rst_ni(reset),
    .load_i(pc_load),
    .pc_d_i(pc_d),
    .pc_q_o(pc_q)
  );

  // Next-PC select: redirect beats sequential advance; advance only on an accepted fetch
  always_comb begin
    pc_load = 1'b0;
    pc_d    = pc_q;
    if (state_q == FETCH || state_q == STALL) begin
      if (br_taken) begin
        if (!br_fault) begin
          pc_load = 1'b1;
          pc_d    = br_target_aligned;
        end
      end else if (state_q == FETCH && !stall && imem_ready) begin
        pc_load = 1'b1;
        pc_d    = pc_inc;
      end
    end
  end

  // Fetch FSM with registered IF/ID-facing outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= BOOT;
      req_q      <= 1'b0;
      flush_q    <= 1'b1;
      valid_q    <= 1'b0;
      instr_q    <= NOP_W;
      curr_pc_q  <= '0;
      pc_plus4_q <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      align_fault_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        BOOT: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
          flush_q <= 1'b1;
        end
        FAULT: begin
          req_q   <= 1'b0;
          flush_q <= 1'b1;
        end
        default: begin
          if (br_taken) begin
            // Any response arriving alongside the redirect belongs to the wrong path
            instr_q <= NOP_W;
            valid_q <= 1'b0;
            flush_q <= 1'b1;
            if (br_fault) begin
              state_q <= FAULT;
              req_q   <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
              align_fault_q <= 1'b1;
`endif
            end else begin
              state_q <= FETCH;
              req_q   <= 1'b1;
            end
          end else if (stall) begin
            // A response landing in the stall cycle is dropped; pc was not advanced so it is refetched
            state_q <= STALL;
            req_q   <= 1'b0;
            flush_q <= 1'b0;
          end else if (state_q == STALL) begin
            state_q <= FETCH;
            req_q   <= 1'b1;
            flush_q <= 1'b0;
          end else if (imem_ready) begin
            instr_q    <= imem_rdata;
            curr_pc_q  <= pc_q;
            pc_plus4_q <= pc_inc;
            valid_q    <= 1'b1;
            flush_q    <= 1'b0;
          end else begin
            instr_q <= NOP_W;
            valid_q <= 1'b0;
            flush_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instruction = instr_q;
  assign currPC      = curr_pc_q;
  assign pc_plus4    = pc_plus4_q;
  assign IF_ID_flush = flush_q;
  assign fetch_valid = valid_q;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Producer side of the IF/ID pipeline register.
- Owns the program counter and issues single-outstanding requests to instruction memory.
- Presents instruction, currPC, pc_plus4 and IF_ID_flush to IF/ID.
- Handles hazard-unit stalls, branch redirects and bubble insertion, so IF/ID only ever captures a valid instruction or a NOP bubble.

Parameters:
- PC_W, 64, program counter / address width.
- INSTR_W, 32, instruction width.
- RESET_PC, 64'd0, first fetch address after reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- stall  input  1  hazard-unit hold; freeze PC and fetch outputs.
- br_taken  input  1  branch resolved taken; redirect this cycle.
- br_target  input  PC_W  redirect address.
- imem_req  output  1  fetch request valid.
- imem_addr  output  PC_W  fetch address (equals pc).
- imem_ready  input  1  imem_rdata valid for the current request.
- imem_rdata  input  INSTR_W  fetched instruction word.
- instruction  output  INSTR_W  to IF/ID.
- currPC  output  PC_W  address of instruction, to IF/ID.
- pc_plus4  output  PC_W  currPC+4, to IF/ID.
- IF_ID_flush  output  1  force bubble in IF/ID.
- fetch_valid  output  1  instruction holds a real fetched word.

Behaviour:
- All outputs are registered on the rising clk edge, so they are stable before IF/ID samples on the falling edge.
- Reset (reset=0, async) values:
  - pc=RESET_PC; state=BOOT.
  - instruction=NOP.
  - currPC=0; pc_plus4=0.
  - IF_ID_flush=1; fetch_valid=0; imem_req=0.
- States:
  - BOOT: one cycle after reset release. imem_req=0, IF_ID_flush=1. Next state is FETCH.
  - FETCH: imem_req=1, imem_addr=pc.
    - On imem_ready with no branch and no stall: instruction<=imem_rdata, currPC<=pc, pc_plus4<=pc+4, fetch_valid<=1, IF_ID_flush<=0, pc<=pc+4.
    - On no imem_ready: instruction<=NOP, fetch_valid<=0, IF_ID_flush<=0 (bubble via NOP). Stay in FETCH with the same pc.
  - STALL: imem_req=0. pc, instruction, currPC, pc_plus4 and fetch_valid are held. Return to FETCH in the cycle after stall deasserts.
- Priority: reset > br_taken > stall > normal fetch.
- br_taken (any state except BOOT):
  - pc<=br_target; instruction<=NOP; fetch_valid<=0.
  - IF_ID_flush<=1 for exactly one cycle.
  - Any imem_ready/imem_rdata in the same cycle is discarded.
  - Next state is FETCH.
  - br_taken with stall: the branch wins, and stall is re-evaluated the next cycle.
- stall in FETCH (no br_taken): enter STALL. A same-cycle imem_ready response is dropped and refetched later; pc is not advanced.
- Latency: request issued at cycle N with imem_ready at N → outputs valid at N+1.
- Arithmetic: pc+4 wraps modulo 2^PC_W. br_target[1:0] is ignored (forced to 00) unless the optional feature is enabled.
- Reset mid-request: the outstanding request is abandoned immediately. imem_req drops asynchronously with reset.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- When defined:
  - Adds output align_fault (1 bit, reset 0) and state FAULT.
  - On br_taken with br_target[1:0]!=0: enter FAULT, set align_fault=1 (sticky until reset), imem_req=0, IF_ID_flush=1 held continuously.
  - FAULT is left only by reset.
- When undefined: no align_fault port and no FAULT state; low bits are masked as above.

Decomposition:
- Package fetch_pkg:
  - typedef enum fetch_state_t {BOOT, FETCH, STALL, FAULT}.
  - localparam NOP_INSTR = 32'hD503201F.
  - localparam PC_INCR = 4.
- One sub-module, pc_reg: PC_W-bit register with async active-low reset to RESET_PC and load enable. It is instantiated once; the next-pc mux stays in the top level.

Test Plan:
- Reset release with imem_ready=1, rdata=32'hF8405087: BOOT cycle with IF_ID_flush=1, imem_req=0. Next cycle imem_addr=0. Following cycle instruction=F8405087, currPC=0, pc_plus4=4, fetch_valid=1.
- Streaming fetch, ready every cycle from pc=200: currPC sequence 200, 204, 208 and pc_plus4 sequence 204, 208, 212 on consecutive cycles; IF_ID_flush=0 throughout.
- stall held 3 cycles while pc=208: imem_req=0, outputs frozen at currPC=204 for 3 cycles. The first cycle after release refetches 208.
- br_taken with br_target=64'd400 coincident with imem_ready: IF_ID_flush=1 for exactly one cycle, instruction=NOP, fetch_valid=0, rdata dropped. The next request has imem_addr=400.
- imem_ready low for 2 cycles: two NOP bubbles with fetch_valid=0 and pc unchanged; resumes on ready. Asserting reset=0 mid-sequence returns all outputs to their reset values asynchronously.
- With FETCH_ALIGN_CHECK_EN, br_target=64'd402: align_fault=1, imem_req=0, IF_ID_flush stays 1 until reset; without the macro the next fetch is at 400.
